// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and types for the up/down counter
package counter_pkg;
    localparam int COUNTER_WIDTH_DEFAULT = 8;
    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;
endpackage

// File: rtl/counter_ud_if.sv
// counter_ud_if: direction input and count output of the up/down counter
interface counter_ud_if import counter_pkg::*; #(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
);
    logic             ud;
    logic [WIDTH-1:0] q;
    modport master (output ud, input q);
    modport slave (input ud, output q);
endinterface

// File: rtl/counter_ud_step.sv
// counter_ud_step: combinational d +/- 1 modulo 2^WIDTH, reusable by other counters
module counter_ud_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    output logic [WIDTH-1:0] y
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    // wrap-around is the natural modulo behaviour of WIDTH-bit arithmetic
    always_comb y = up ? d + ONE : d - ONE;
endmodule

// File: rtl/counter_ud.sv
// counter_ud: free-running WIDTH-bit up/down counter with async active-high reset
module counter_ud import counter_pkg::*; #(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input logic         clk,
    input logic         reset,
    counter_ud_if.slave bus
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] nxt;
    counter_ud_step #(.WIDTH(WIDTH)) u_step (
        .d  (cnt),
        .up (bus.ud),
        .y  (nxt)
    );
    // count register: cleared immediately by reset, steps on every rising edge otherwise
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= nxt;
    assign bus.q = cnt;
endmodule

// File: tb/tb_counter_ud.sv
// tb_counter_ud: randomized self-checking bench for counter_ud against a modulo-256 model
module tb_counter_ud;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   exp_q = 0;
    counter_ud_if #(.WIDTH(8)) bus ();
    counter_ud #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    // one rising edge with direction d; model tracks the count as plain modular arithmetic
    task automatic step(input bit d);
        bus.ud = d;
        @(posedge clk);
        #1;
        exp_q = d ? (exp_q + 1) % 256 : (exp_q + 255) % 256;
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q = 0;
    endtask
    task automatic test_reset();
        bus.ud = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.q !== 8'd0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: q=%0d expected 0", i, bus.q);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q = 0;
        step(1'b1);
        checks++;
        if (bus.q !== 8'd1) begin
            failures++;
            $display("FAIL reset_release: q=%0d expected 1", bus.q);
        end
    endtask
    task automatic test_count_up();
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step(1'b1);
            checks++;
            if (bus.q !== 8'(exp_q) || exp_q != i) begin
                failures++;
                $display("FAIL count_up edge %0d: q=%0d expected %0d", i, bus.q, i);
            end
        end
    endtask
    task automatic test_direction_change();
        step(1'b0);
        checks++;
        if (bus.q !== 8'd39) begin
            failures++;
            $display("FAIL dir_change_first: q=%0d expected 39", bus.q);
        end
        for (int i = 0; i < 39; i++) step(1'b0);
        checks++;
        if (bus.q !== 8'd0) begin
            failures++;
            $display("FAIL dir_change_down_to_zero: q=%0d expected 0", bus.q);
        end
    endtask
    task automatic test_up_wrap();
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            step(1'b1);
            if (i == 255 || i == 256) begin
                checks++;
                if (bus.q !== 8'(i % 256)) begin
                    failures++;
                    $display("FAIL up_wrap edge %0d: q=%0d expected %0d", i, bus.q, i % 256);
                end
            end
        end
    endtask
    task automatic test_down_wrap();
        do_reset();
        step(1'b0);
        checks++;
        if (bus.q !== 8'd255) begin
            failures++;
            $display("FAIL down_wrap_first: q=%0d expected 255", bus.q);
        end
        step(1'b0);
        checks++;
        if (bus.q !== 8'd254) begin
            failures++;
            $display("FAIL down_wrap_second: q=%0d expected 254", bus.q);
        end
    endtask
    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1);
        checks++;
        if (bus.q !== 8'd100) begin
            failures++;
            $display("FAIL async_pre: q=%0d expected 100", bus.q);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.q !== 8'd0) begin
            failures++;
            $display("FAIL async_immediate: q=%0d expected 0", bus.q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 8'd0) begin
            failures++;
            $display("FAIL async_held: q=%0d expected 0", bus.q);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q = 0;
        step(1'b1);
        checks++;
        if (bus.q !== 8'd1) begin
            failures++;
            $display("FAIL async_resume: q=%0d expected 1", bus.q);
        end
    endtask
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                exp_q = 0;
                checks++;
                if (bus.q !== 8'd0) begin
                    failures++;
                    $display("FAIL random_async_reset %0d: q=%0d expected 0", i, bus.q);
                end
                @(negedge clk);
                reset = 1'b0;
            end
            step(1'($urandom_range(0, 1)));
            checks++;
            if (bus.q !== 8'(exp_q)) begin
                failures++;
                $display("FAIL random_step %0d: q=%0d expected %0d", i, bus.q, exp_q);
            end
        end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        bus.ud = 1'b1;
        test_reset();
        test_count_up();
        test_direction_change();
        test_up_wrap();
        test_down_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
